muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle unsigned multiply/divide unit sitting beside main_alu in the execute stage.
//  Accepts one op per start pulse and iterates one shift-add / restoring-subtract step per clock.
//  Holds the pipeline via stall until the result is ready, then presents it for one-cycle writeback.
//  Keeps long-latency MUL/DIV out of the single-cycle ALU path.
// PARAMETERS
//  W      16   operand width; product is 2W, quotient/remainder are W each
//  CNT_W  $clog2(W)+1   iteration counter width (derived, do not override)
// PORTS
//  clk          in   1    system clock; all state on rising edge
//  rst          in   1    synchronous, active-high reset
//  start        in   1    request; sampled only in IDLE
//  op_div       in   1    0 = multiply, 1 = divide (sampled with start)
//  a            in   W    multiplicand / dividend (sampled with start)
//  b            in   W    multiplier / divisor (sampled with start)
//  flush        in   1    abort current op (branch squash); synchronous
//  busy         out  1    high in MUL_RUN, DIV_RUN, DONE
//  stall        out  1    combinational: busy | (start & state==IDLE)
//  done         out  1    one-cycle pulse, result valid this cycle
//  result_lo    out  W    MUL: product[W-1:0]; DIV: quotient
//  result_hi    out  W    MUL: product[2W-1:W]; DIV: remainder
//  div_by_zero  out  1    valid with done; high iff op_div & b==0
// BEHAVIOUR
//  Reset: state=IDLE, count=0, busy=0, done=0, div_by_zero=0, result_lo=0, result_hi=0.
//  FSM states: IDLE, MUL_RUN, DIV_RUN, DONE.
//   IDLE -> MUL_RUN on start & !op_div; -> DIV_RUN on start & op_div & b!=0;
//   IDLE -> DONE on start & op_div & b==0 (no iterations).
//   MUL_RUN/DIV_RUN -> DONE when count==W-1 at the clock edge (after W iterations).
//   DONE -> IDLE unconditionally after one cycle.
//  Latency: start sampled at edge N; done high during cycle N+W+1 (N+2 for div-by-zero).
//  Multiply: acc[2W-1:0] cleared at start; each step: if mplr[0] add mcand<<count into acc, mplr>>=1.
//   Full 2W result, no overflow, no truncation.
//  Divide (restoring): rem W+1 bits, quotient shifts in MSB-first;
//   each step rem = {rem,dvd[msb]}; if rem>=b then rem-=b, q bit=1 else q bit=0.
//  Div-by-zero: result_lo = {W{1'b1}}, result_hi = a, div_by_zero = 1.
//  result_lo/hi update only on entry to DONE; hold until the next start is accepted.
//  start while busy: ignored, no queuing; requester must hold start until stall drops.
//  start in the same cycle as DONE: ignored; accepted in the following IDLE cycle.
//  flush: any state -> IDLE next edge, done suppressed, results unchanged.
//   flush & start in IDLE: flush wins, op not accepted.
//  rst mid-operation: IDLE next edge, all outputs return to reset values; rst has priority over flush/start.
//  done and busy are never high outside DONE/RUN states; done never asserts twice per op.
// TESTING
//  1 MUL W=16, a=300, b=200 -> done at cycle 17 after start, hi=0x0000, lo=0xEA60.
//  2 MUL a=0xFFFF, b=0xFFFF -> hi=0xFFFE, lo=0x0001; stall high for 17 cycles.
//  3 DIV a=100, b=7 -> lo=14, hi=2, div_by_zero=0, done at cycle 17.
//  4 DIV a=5, b=0 -> done at cycle 2, lo=0xFFFF, hi=0x0005, div_by_zero=1.
//  5 start pulsed mid-MUL with new operands -> ignored; first result intact; exactly one done.
//  6 rst at iteration 8 -> next cycle busy=0, results=0, no done;
//    flush at iteration 8 -> IDLE, no done, prior result held; fresh op completes correctly.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply / restoring divide beside the single-cycle ALU.
// Latency: done W cycles after the start cycle (start cycle + W-1 run + done); div-by-zero: done the cycle after start.
// Backpressure: stall holds the pipeline from accepted start through done; start while busy is dropped, not queued.
module muldiv_sequencer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         op_div,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         flush,
   output logic         busy,
   output logic         stall,
   output logic         done,
   output logic [W-1:0] result_lo,
   output logic [W-1:0] result_hi,
   output logic         div_by_zero
);

   localparam int CNT_W = $clog2(W) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [2*W-1:0]   acc_q, acc_d;      // multiply accumulator
   logic [W-1:0]     opa_q, opa_d;      // multiplicand, or dividend shifting into quotient
   logic [W-1:0]     opb_q, opb_d;      // multiplier (shifts right), or divisor (static)
   logic [W:0]       rem_q, rem_d;      // partial remainder
   logic [W-1:0]     res_lo_q, res_lo_d;
   logic [W-1:0]     res_hi_q, res_hi_d;
   logic             dbz_q, dbz_d;

   // Step operands: the first iteration runs on the accepting edge straight from the
   // input ports, so W iterations finish after W-1 cycles in the run state.
   logic [2*W-1:0]   step_acc;
   logic [W-1:0]     step_a;
   logic [W-1:0]     step_b;
   logic [W:0]       step_rem;
   logic [CNT_W-1:0] step_cnt;

   logic [2*W-1:0]   mul_addend;
   logic [2*W-1:0]   mul_acc_nx;
   logic [W-1:0]     mul_mplr_nx;
   logic [W:0]       div_trial;
   logic             div_ge;
   logic [W:0]       div_rem_nx;
   logic [W-1:0]     div_dvd_nx;
   logic             last_step;

   // Select where the current iteration reads its operands from.
   always_comb begin
      step_acc = acc_q;
      step_a   = opa_q;
      step_b   = opb_q;
      step_rem = rem_q;
      step_cnt = count_q;
      if (state_q == IDLE) begin
         step_acc = '0;
         step_a   = a;
         step_b   = b;
         step_rem = '0;
         step_cnt = '0;
      end
   end

   // One shift-add multiply step and one restoring-divide step, both always computed.
   always_comb begin
      mul_addend  = {{W{1'b0}}, step_a} << step_cnt;
      mul_acc_nx  = step_b[0] ? (step_acc + mul_addend) : step_acc;
      mul_mplr_nx = step_b >> 1;
      div_trial   = {step_rem[W-1:0], step_a[W-1]};
      div_ge      = (div_trial >= {1'b0, step_b});
      div_rem_nx  = div_ge ? (div_trial - {1'b0, step_b}) : div_trial;
      div_dvd_nx  = {step_a[W-2:0], div_ge};
   end

   assign last_step = (count_q == CNT_W'(W - 1));

   // Next-state, datapath and result-capture logic; flush overrides everything but reset.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      rem_d    = rem_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      dbz_d    = dbz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (op_div && (b == '0)) begin
                  state_d  = DONE;
                  res_lo_d = '1;
                  res_hi_d = a;
                  dbz_d    = 1'b1;
               end else if (op_div) begin
                  state_d = DIV_RUN;
                  opa_d   = div_dvd_nx;
                  opb_d   = b;
                  rem_d   = div_rem_nx;
                  count_d = CNT_W'(1);
               end else begin
                  state_d = MUL_RUN;
                  acc_d   = mul_acc_nx;
                  opa_d   = a;
                  opb_d   = mul_mplr_nx;
                  count_d = CNT_W'(1);
               end
            end
         end
         MUL_RUN: begin
            acc_d   = mul_acc_nx;
            opb_d   = mul_mplr_nx;
            count_d = count_q + CNT_W'(1);
            if (last_step) begin
               state_d  = DONE;
               count_d  = '0;
               res_lo_d = mul_acc_nx[W-1:0];
               res_hi_d = mul_acc_nx[2*W-1:W];
               dbz_d    = 1'b0;
            end
         end
         DIV_RUN: begin
            opa_d   = div_dvd_nx;
            rem_d   = div_rem_nx;
            count_d = count_q + CNT_W'(1);
            if (last_step) begin
               state_d  = DONE;
               count_d  = '0;
               res_lo_d = div_dvd_nx;
               res_hi_d = div_rem_nx[W-1:0];
               dbz_d    = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
            count_d = '0;
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase

      if (flush) begin
         state_d  = IDLE;
         count_d  = '0;
         res_lo_d = res_lo_q;
         res_hi_d = res_hi_q;
         dbz_d    = dbz_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         acc_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         rem_q    <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         rem_q    <= rem_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign stall       = busy | (start & (state_q == IDLE));
   assign result_lo   = res_lo_q;
   assign result_hi   = res_hi_q;
   assign div_by_zero = dbz_q & done;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed and random ops against an arithmetic reference.
// Expected: done in cycle 17 counting the start cycle as 1 (cycle 2 for divide-by-zero).
// Inputs driven on the falling edge; outputs sampled 1ns later.
module tb_muldiv_sequencer;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst, start, op_div, flush;
   logic [W-1:0] a, b;
   logic         busy, stall, done, div_by_zero;
   logic [W-1:0] result_lo, result_hi;

   int tests = 0;
   int fails = 0;

   muldiv_sequencer #(.W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op_div(op_div), .a(a), .b(b), .flush(flush),
      .busy(busy), .stall(stall), .done(done), .result_lo(result_lo), .result_hi(result_hi),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference: plain arithmetic; returns expected {hi, lo}, dbz, done cycle and stall count.
   function automatic void model(input logic d, input logic [W-1:0] ia, ib,
                                 output logic [W-1:0] lo, hi, output logic dz,
                                 output int lat, output int stl);
      logic [2*W-1:0] p;
      if (d && ib == 0) begin
         lo = '1; hi = ia; dz = 1'b1; lat = 2; stl = 2;
      end else if (d) begin
         lo = ia / ib; hi = ia % ib; dz = 1'b0; lat = W + 1; stl = W + 1;
      end else begin
         p = (2*W)'(ia) * (2*W)'(ib);
         lo = p[W-1:0]; hi = p[2*W-1:W]; dz = 1'b0; lat = W + 1; stl = W + 1;
      end
   endfunction

   // Drive one op for a fixed 40-cycle window and record what the DUT did.
   task automatic run_op(input logic d, input logic [W-1:0] ia, ib,
                         output int lat, output int stl, output int dones,
                         output logic [W-1:0] lo, hi, output logic dz);
      lat = 0; stl = 0; dones = 0; lo = '0; hi = '0; dz = 1'b0;
      @(negedge clk);
      start = 1'b1; op_div = d; a = ia; b = ib;
      #1 if (stall) stl++;
      for (int c = 2; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0; a = W'($urandom); b = W'($urandom);
         #1;
         if (stall) stl++;
         if (done) begin
            dones++;
            if (lat == 0) begin
               lat = c; lo = result_lo; hi = result_hi; dz = div_by_zero;
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; op_div = 1'b0; flush = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
      tests++; if ({result_hi, result_lo} !== '0) begin fails++; $display("FAIL reset_result got %h want 0", {result_hi, result_lo}); end
      tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
      rst = 1'b0;
   endtask

   // Directed cases from the block's worked examples plus a random sweep.
   task automatic test_ops(input int n_random);
      logic d; logic [W-1:0] ia, ib, lo, hi, elo, ehi; logic dz, edz;
      int lat, stl, dones, elat, estl;
      for (int i = 0; i < 4 + n_random; i++) begin
         case (i)
            0: begin d = 1'b0; ia = 16'd300;  ib = 16'd200;  end
            1: begin d = 1'b0; ia = 16'hFFFF; ib = 16'hFFFF; end
            2: begin d = 1'b1; ia = 16'd100;  ib = 16'd7;    end
            3: begin d = 1'b1; ia = 16'd5;    ib = 16'd0;    end
            default: begin
               d = 1'($urandom_range(0, 1)); ia = W'($urandom); ib = W'($urandom);
               case ($urandom_range(0, 7))
                  0: ib = '0;
                  1: ia = '1;
                  2: ib = 16'd1;
                  3: ib = '1;
                  default: ;
               endcase
            end
         endcase
         model(d, ia, ib, elo, ehi, edz, elat, estl);
         run_op(d, ia, ib, lat, stl, dones, lo, hi, dz);
         tests++; if (lat !== elat) begin fails++; $display("FAIL op%0d_latency d=%b a=%h b=%h got %0d want %0d", i, d, ia, ib, lat, elat); end
         tests++; if (stl !== estl) begin fails++; $display("FAIL op%0d_stall_cycles got %0d want %0d", i, stl, estl); end
         tests++; if (dones !== 1) begin fails++; $display("FAIL op%0d_done_count got %0d want 1", i, dones); end
         tests++; if (lo !== elo) begin fails++; $display("FAIL op%0d_lo d=%b a=%h b=%h got %h want %h", i, d, ia, ib, lo, elo); end
         tests++; if (hi !== ehi) begin fails++; $display("FAIL op%0d_hi d=%b a=%h b=%h got %h want %h", i, d, ia, ib, hi, ehi); end
         tests++; if (dz !== edz) begin fails++; $display("FAIL op%0d_dbz got %b want %b", i, dz, edz); end
         tests++; if (result_lo !== elo || result_hi !== ehi) begin fails++; $display("FAIL op%0d_hold got %h%h want %h%h", i, result_hi, result_lo, ehi, elo); end
      end
   endtask

   task automatic test_start_while_busy;
      logic [W-1:0] elo, ehi, lo, hi; logic edz; int elat, estl, dones, lat;
      model(1'b0, 16'd1234, 16'd567, elo, ehi, edz, elat, estl);
      dones = 0; lat = 0; lo = '0; hi = '0;
      @(negedge clk);
      start = 1'b1; op_div = 1'b0; a = 16'd1234; b = 16'd567;
      for (int c = 2; c <= 40; c++) begin
         @(negedge clk);
         start = (c == 5);
         if (c == 5) begin a = 16'd9999; b = 16'd7777; op_div = 1'($urandom_range(0, 1)); end
         #1;
         if (done) begin
            dones++;
            if (lat == 0) begin lat = c; lo = result_lo; hi = result_hi; end
         end
      end
      tests++; if (dones !== 1) begin fails++; $display("FAIL busy_start_done_count got %0d want 1", dones); end
      tests++; if (lat !== elat) begin fails++; $display("FAIL busy_start_latency got %0d want %0d", lat, elat); end
      tests++; if ({hi, lo} !== {ehi, elo}) begin fails++; $display("FAIL busy_start_result got %h%h want %h%h", hi, lo, ehi, elo); end
   endtask

   // Start held high across DONE: second op is taken the cycle after DONE, not during it.
   task automatic test_back_to_back;
      logic [W-1:0] elo, ehi; logic edz; int elat, estl, first, second;
      logic [W-1:0] lo2, hi2;
      model(1'b1, 16'd50000, 16'd123, elo, ehi, edz, elat, estl);
      first = 0; second = 0; lo2 = '0; hi2 = '0;
      @(negedge clk);
      start = 1'b1; op_div = 1'b0; a = 16'd77; b = 16'd88;
      for (int c = 2; c <= 50; c++) begin
         @(negedge clk);
         if (c == 17) begin op_div = 1'b1; a = 16'd50000; b = 16'd123; end
         if (c == 19) start = 1'b0;
         #1;
         if (done) begin
            if (first == 0) first = c;
            else if (second == 0) begin second = c; lo2 = result_lo; hi2 = result_hi; end
         end
      end
      tests++; if (first !== W + 1) begin fails++; $display("FAIL b2b_first_done got %0d want %0d", first, W + 1); end
      tests++; if (second !== 18 + W) begin fails++; $display("FAIL b2b_second_done got %0d want %0d", second, 18 + W); end
      tests++; if ({hi2, lo2} !== {ehi, elo}) begin fails++; $display("FAIL b2b_second_result got %h%h want %h%h", hi2, lo2, ehi, elo); end
   endtask

   task automatic test_rst_mid;
      int dones;
      dones = 0;
      @(negedge clk);
      start = 1'b1; op_div = 1'b0; a = 16'd321; b = 16'd654;
      for (int c = 2; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         rst = (c == 9);
         #1;
         if (done) dones++;
         if (c == 10) begin
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
            tests++; if ({result_hi, result_lo} !== '0) begin fails++; $display("FAIL rst_mid_result got %h want 0", {result_hi, result_lo}); end
         end
      end
      tests++; if (dones !== 0) begin fails++; $display("FAIL rst_mid_done_count got %0d want 0", dones); end
   endtask

   task automatic test_flush;
      logic [W-1:0] elo, ehi, lo, hi; logic edz, dz; int elat, estl, lat, stl, dones;
      model(1'b0, 16'd4000, 16'd3000, elo, ehi, edz, elat, estl);
      run_op(1'b0, 16'd4000, 16'd3000, lat, stl, dones, lo, hi, dz);
      dones = 0;
      @(negedge clk);
      start = 1'b1; op_div = 1'b1; a = 16'd999; b = 16'd10;
      for (int c = 2; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         flush = (c == 9);
         #1;
         if (done) dones++;
         if (c == 10) begin
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %b want 0", busy); end
            tests++; if ({result_hi, result_lo} !== {ehi, elo}) begin fails++; $display("FAIL flush_held got %h%h want %h%h", result_hi, result_lo, ehi, elo); end
         end
      end
      tests++; if (dones !== 0) begin fails++; $display("FAIL flush_done_count got %0d want 0", dones); end
      // flush together with start in IDLE: op must not be accepted
      dones = 0;
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op_div = 1'b0; a = 16'd3; b = 16'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_start_busy got %b want 0", busy); end
      for (int c = 0; c < 25; c++) begin
         @(negedge clk); #1;
         if (done) dones++;
      end
      tests++; if (dones !== 0) begin fails++; $display("FAIL flush_start_done_count got %0d want 0", dones); end
      // fresh op after the aborted one
      model(1'b1, 16'd999, 16'd10, elo, ehi, edz, elat, estl);
      run_op(1'b1, 16'd999, 16'd10, lat, stl, dones, lo, hi, dz);
      tests++; if (lat !== elat) begin fails++; $display("FAIL flush_fresh_latency got %0d want %0d", lat, elat); end
      tests++; if ({hi, lo} !== {ehi, elo}) begin fails++; $display("FAIL flush_fresh_result got %h%h want %h%h", hi, lo, ehi, elo); end
   endtask

   initial begin
      test_reset();
      test_ops(30);
      test_start_while_busy();
      test_back_to_back();
      test_rst_mid();
      test_flush();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
